// File: rtl/approx_product_accumulator_if.sv
// Stream bundle for the product accumulator: product in, accumulated sum out.
// With ACC_ERR_STAT_EN defined it also carries the exact product and error statistics.
interface approx_product_accumulator_if #(
   parameter int ACC_W = 19
);
   logic [15:0]      prod;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] sum;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;
`ifdef ACC_ERR_STAT_EN
   logic [15:0]      prod_exact;
   logic [ACC_W-1:0] err_sum;
   logic [15:0]      err_max;

   modport slave  (input  prod, in_valid, out_ready, prod_exact,
                   output in_ready, sum, ovf, out_valid, err_sum, err_max);
   modport master (output prod, in_valid, out_ready, prod_exact,
                   input  in_ready, sum, ovf, out_valid, err_sum, err_max);
`else
   modport slave  (input  prod, in_valid, out_ready,
                   output in_ready, sum, ovf, out_valid);
   modport master (output prod, in_valid, out_ready,
                   input  in_ready, sum, ovf, out_valid);
`endif
endinterface

// File: rtl/approx_product_accumulator.sv
// Sums ACC_LEN unsigned 16-bit products into a saturating ACC_W-bit result held until taken.
// Optional macro ACC_ERR_STAT_EN adds |exact - approx| sum and max statistics.
module approx_product_accumulator #(
   parameter int ACC_LEN = 8,
   parameter int ACC_W   = 19,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   approx_product_accumulator_if.slave  io
);
   localparam int              AW   = ACC_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

   typedef enum logic {S_ACC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stk_q, stk_d, ovf_q, ovf_d;
   logic [AW-1:0]    add;
   logic [ACC_W-1:0] sat;
   logic             in_ready, accept;

   assign in_ready = (state_q == S_ACC) && !clr && !rst;
   assign accept   = io.in_valid && in_ready;
   // Carry bit of the widened add is the overflow flag; saturate on it.
   assign add      = {1'b0, acc_q} + AW'(io.prod);
   assign sat      = add[ACC_W] ? '1 : add[ACC_W-1:0];

`ifdef ACC_ERR_STAT_EN
   logic [ACC_W-1:0] eacc_q, eacc_d, esum_q, esum_d, esat;
   logic [15:0]      emax_q, emax_d, emx_q, emx_d, e, emx;
   logic [AW-1:0]    eadd;

   assign e    = (io.prod_exact >= io.prod) ? io.prod_exact - io.prod : io.prod - io.prod_exact;
   assign eadd = {1'b0, eacc_q} + AW'(e);
   assign esat = eadd[ACC_W] ? '1 : eadd[ACC_W-1:0];
   assign emx  = (e > emax_q) ? e : emax_q;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      stk_d   = stk_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
`ifdef ACC_ERR_STAT_EN
      eacc_d  = eacc_q;
      emax_d  = emax_q;
      esum_d  = esum_q;
      emx_d   = emx_q;
`endif
      case (state_q)
         S_ACC: begin
            if (accept) begin
               if (cnt_q == LAST) begin
                  sum_d   = sat;
                  ovf_d   = stk_q | add[ACC_W];
                  acc_d   = '0;
                  cnt_d   = '0;
                  stk_d   = 1'b0;
                  state_d = S_DONE;
`ifdef ACC_ERR_STAT_EN
                  esum_d  = esat;
                  emx_d   = emx;
                  eacc_d  = '0;
                  emax_d  = '0;
`endif
               end else begin
                  acc_d   = sat;
                  cnt_d   = cnt_q + CNT_W'(1);
                  stk_d   = stk_q | add[ACC_W];
`ifdef ACC_ERR_STAT_EN
                  eacc_d  = esat;
                  emax_d  = emx;
`endif
               end
            end
         end
         S_DONE: if (io.out_ready) state_d = S_ACC;
         default: state_d = S_ACC;
      endcase
      // Flush wins over both handshakes: nothing accepted, nothing delivered.
      if (clr) begin
         state_d = S_ACC;
         acc_d   = '0;
         cnt_d   = '0;
         stk_d   = 1'b0;
         sum_d   = '0;
         ovf_d   = 1'b0;
`ifdef ACC_ERR_STAT_EN
         eacc_d  = '0;
         emax_d  = '0;
         esum_d  = '0;
         emx_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         stk_q   <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
`ifdef ACC_ERR_STAT_EN
         eacc_q  <= '0;
         emax_q  <= '0;
         esum_q  <= '0;
         emx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         stk_q   <= stk_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
`ifdef ACC_ERR_STAT_EN
         eacc_q  <= eacc_d;
         emax_q  <= emax_d;
         esum_q  <= esum_d;
         emx_q   <= emx_d;
`endif
      end
   end

   assign io.in_ready  = in_ready;
   assign io.out_valid = (state_q == S_DONE);
   assign io.sum       = sum_q;
   assign io.ovf       = ovf_q;
`ifdef ACC_ERR_STAT_EN
   assign io.err_sum   = esum_q;
   assign io.err_max   = emx_q;
`endif
endmodule

// File: tb/tb_approx_product_accumulator.sv
// Two accumulators (19-bit and 16-bit result) share one stimulus stream and are
// compared each cycle against a queue-based model, plus fixed vectors and corner sequences.
module tb_approx_product_accumulator;
   localparam int      LEN   = 4;
   localparam longint  MAX_A = 524287;
   localparam longint  MAX_B = 65535;

   logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
   logic [15:0] prod = '0, pex = '0;
   logic iv = 1'b0, ordy = 1'b0;

   always #5 clk = ~clk;

   approx_product_accumulator_if #(.ACC_W(19)) ia ();
   approx_product_accumulator_if #(.ACC_W(16)) ib ();

   assign ia.prod = prod;  assign ia.in_valid = iv;  assign ia.out_ready = ordy;
   assign ib.prod = prod;  assign ib.in_valid = iv;  assign ib.out_ready = ordy;
`ifdef ACC_ERR_STAT_EN
   assign ia.prod_exact = pex;
   assign ib.prod_exact = pex;
`endif

   approx_product_accumulator #(.ACC_LEN(LEN), .ACC_W(19), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .io(ia));
   approx_product_accumulator #(.ACC_LEN(LEN), .ACC_W(16), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .io(ib));

   int nvec = 0, nerr = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", n, act, act, exp, exp, $time);
      end
   endtask

   // Reference: a result is the plain sum of the LEN accepted products, clamped.
   longint q[$];
   longint eq[$];
   bit     pend = 1'b0;
   longint es_a = 0, es_b = 0;
   bit     eo_a = 1'b0, eo_b = 1'b0;
   longint ee_a = 0, ee_b = 0, ee_m = 0;

   always @(posedge clk) begin
      longint tot, et, em;
      if (rst || clr) begin
         q.delete(); eq.delete();
         pend = 1'b0;
         es_a = 0; es_b = 0; eo_a = 1'b0; eo_b = 1'b0;
         ee_a = 0; ee_b = 0; ee_m = 0;
      end else if (pend) begin
         if (ordy) pend = 1'b0;
      end else if (iv) begin
         q.push_back(longint'(prod));
         eq.push_back((pex >= prod) ? longint'(pex) - longint'(prod) : longint'(prod) - longint'(pex));
         if (q.size() == LEN) begin
            tot = 0; et = 0; em = 0;
            foreach (q[k]) tot += q[k];
            foreach (eq[k]) begin et += eq[k]; if (eq[k] > em) em = eq[k]; end
            es_a = (tot > MAX_A) ? MAX_A : tot;  eo_a = (tot > MAX_A);
            es_b = (tot > MAX_B) ? MAX_B : tot;  eo_b = (tot > MAX_B);
            ee_a = (et > MAX_A) ? MAX_A : et;
            ee_b = (et > MAX_B) ? MAX_B : et;
            ee_m = em;
            pend = 1'b1;
            q.delete(); eq.delete();
         end
      end
   end

   bit mon = 1'b0;
   always @(negedge clk) begin
      if (mon) begin
         chk("mon_in_ready_a", 32'(ia.in_ready), 32'(!pend && !clr && !rst));
         chk("mon_in_ready_b", 32'(ib.in_ready), 32'(!pend && !clr && !rst));
         chk("mon_out_valid_a", 32'(ia.out_valid), 32'(pend));
         chk("mon_out_valid_b", 32'(ib.out_valid), 32'(pend));
         chk("mon_sum_a", 32'(ia.sum), 32'(es_a));
         chk("mon_sum_b", 32'(ib.sum), 32'(es_b));
         chk("mon_ovf_a", 32'(ia.ovf), 32'(eo_a));
         chk("mon_ovf_b", 32'(ib.ovf), 32'(eo_b));
`ifdef ACC_ERR_STAT_EN
         chk("mon_err_sum_a", 32'(ia.err_sum), 32'(ee_a));
         chk("mon_err_sum_b", 32'(ib.err_sum), 32'(ee_b));
         chk("mon_err_max_a", 32'(ia.err_max), 32'(ee_m));
`endif
      end
   end

   task automatic drv(bit v, logic [15:0] p, logic [15:0] px, bit r, bit c, bit rs);
      iv = v; prod = p; pex = px; ordy = r; clr = c; rst = rs;
      @(posedge clk); #1;
   endtask

   task automatic idle(bit r);
      drv(1'b0, 16'hxxxx, 16'hxxxx, r, 1'b0, 1'b0);
   endtask

   typedef struct {
      logic [3:0][15:0] p;
      int               sa;
      bit               oa;
      int               sb;
      bit               ob;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{p: {16'd400, 16'd300, 16'd200, 16'd100}, sa: 1000,   oa: 0, sb: 1000,  ob: 0};
      tbl[1] = '{p: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, sa: 262140, oa: 0, sb: 65535, ob: 1};
      tbl[2] = '{p: {16'd1, 16'd1, 16'd1, 16'd1}, sa: 4, oa: 0, sb: 4, ob: 0};
      tbl[3] = '{p: {16'd0, 16'd0, 16'd0, 16'd0}, sa: 0, oa: 0, sb: 0, ob: 0};
      tbl[4] = '{p: {16'd0, 16'd0, 16'h8000, 16'h8000}, sa: 65536, oa: 0, sb: 65535, ob: 1};
      tbl[5] = '{p: {16'd0, 16'd0, 16'd1, 16'hFFFE}, sa: 65535, oa: 0, sb: 65535, ob: 0};
      tbl[6] = '{p: {16'd0, 16'd0, 16'd1, 16'hFFFF}, sa: 65536, oa: 0, sb: 65535, ob: 1};
      tbl[7] = '{p: {16'd1, 16'hFFFF, 16'd0, 16'd0}, sa: 65536, oa: 0, sb: 65535, ob: 1};

      // Reset state
      @(posedge clk); #1;
      mon = 1'b1;
      chk("rst_in_ready", 32'(ia.in_ready), 32'd0);
      chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
      chk("rst_sum", 32'(ia.sum), 32'd0);
      chk("rst_ovf", 32'(ib.ovf), 32'd0);
      drv(1'b1, 16'd55, 16'd55, 1'b0, 1'b0, 1'b1);
      idle(1'b0);

      // Table vectors, back-to-back beats then one handshake
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < LEN; j++) drv(1'b1, tbl[i].p[j], tbl[i].p[j], 1'b0, 1'b0, 1'b0);
         chk($sformatf("tbl%0d_out_valid", i), 32'(ia.out_valid), 32'd1);
         chk($sformatf("tbl%0d_sum_a", i), 32'(ia.sum), 32'(tbl[i].sa));
         chk($sformatf("tbl%0d_ovf_a", i), 32'(ia.ovf), 32'(tbl[i].oa));
         chk($sformatf("tbl%0d_sum_b", i), 32'(ib.sum), 32'(tbl[i].sb));
         chk($sformatf("tbl%0d_ovf_b", i), 32'(ib.ovf), 32'(tbl[i].ob));
         idle(1'b1);
         chk($sformatf("tbl%0d_out_valid_after", i), 32'(ia.out_valid), 32'd0);
         chk($sformatf("tbl%0d_in_ready_after", i), 32'(ia.in_ready), 32'd1);
      end

      // Hold in DONE with in_valid asserted and out_ready low
      drv(1'b1, 16'd100, 16'd100, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd200, 16'd200, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd300, 16'd300, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd400, 16'd400, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drv(1'b1, 16'd7, 16'd7, 1'b0, 1'b0, 1'b0);
         chk("hold_in_ready", 32'(ia.in_ready), 32'd0);
         chk("hold_sum", 32'(ia.sum), 32'd1000);
         chk("hold_out_valid", 32'(ia.out_valid), 32'd1);
      end
      idle(1'b1);
      for (int k = 0; k < LEN; k++) drv(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
      chk("release_sum", 32'(ia.sum), 32'd4);
      chk("release_out_valid", 32'(ia.out_valid), 32'd1);
      idle(1'b1);

      // clr mid-accumulation, with a beat offered in the clr cycle
      drv(1'b1, 16'd10, 16'd10, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd20, 16'd20, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd10, 16'd10, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= LEN; k++) drv(1'b1, 16'(k), 16'(k), 1'b0, 1'b0, 1'b0);
      chk("clr_sum", 32'(ia.sum), 32'd10);
      chk("clr_out_valid", 32'(ia.out_valid), 32'd1);
      // clr while holding a result drops it
      drv(1'b0, 16'hxxxx, 16'hxxxx, 1'b1, 1'b1, 1'b0);
      chk("clr_done_out_valid", 32'(ia.out_valid), 32'd0);
      chk("clr_done_sum", 32'(ia.sum), 32'd0);

      // rst in DONE with out_ready high
      for (int k = 5; k <= 8; k++) drv(1'b1, 16'(k), 16'(k), 1'b0, 1'b0, 1'b0);
      chk("rstd_sum_before", 32'(ia.sum), 32'd26);
      drv(1'b0, 16'hxxxx, 16'hxxxx, 1'b1, 1'b0, 1'b1);
      chk("rstd_out_valid", 32'(ia.out_valid), 32'd0);
      chk("rstd_sum", 32'(ia.sum), 32'd0);
      for (int k = 0; k < LEN; k++) drv(1'b1, 16'd9, 16'd9, 1'b0, 1'b0, 1'b0);
      chk("rstd_fresh_sum", 32'(ia.sum), 32'd36);
      idle(1'b1);

`ifdef ACC_ERR_STAT_EN
      drv(1'b1, 16'd90,  16'd100, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd210, 16'd200, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd300, 16'd300, 1'b0, 1'b0, 1'b0);
      drv(1'b1, 16'd395, 16'd400, 1'b0, 1'b0, 1'b0);
      chk("err_sum_a", 32'(ia.err_sum), 32'd25);
      chk("err_max_a", 32'(ia.err_max), 32'd10);
      chk("err_sum_b", 32'(ib.err_sum), 32'd25);
      chk("err_prod_sum", 32'(ia.sum), 32'd995);
      idle(1'b1);
`endif

      // Randomized traffic with occasional flush and reset
      for (int k = 0; k < 600; k++) begin
         bit v, r, c, rs;
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         c  = ($urandom_range(0, 39) == 0);
         rs = ($urandom_range(0, 99) == 0);
         if (v) drv(v, 16'($urandom), 16'($urandom), r, c, rs);
         else   drv(v, 16'hxxxx, 16'hxxxx, r, c, rs);
      end

      mon = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
